// File: rtl/dadda_share_arbiter.sv
// Round-robin arbiter time-sharing one 16x16 combinational multiplier among
// NUM_REQ valid/ready requesters; products return tagged with the requester index.

module dadda (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] product
);
    logic [31:0] sum_v;
    logic [31:0] carry_v;
    logic [31:0] pp;
    logic [31:0] tmp;

    // Carry-save reduction of the partial products, one 3:2 row per multiplier bit.
    always_comb begin
        sum_v   = 32'h0000_0000;
        carry_v = 32'h0000_0000;
        pp      = 32'h0000_0000;
        tmp     = 32'h0000_0000;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                pp = {16'h0000, a} << i;
            end else begin
                pp = 32'h0000_0000;
            end
            tmp     = sum_v ^ carry_v ^ pp;
            carry_v = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
            sum_v   = tmp;
        end
        product = sum_v + carry_v;
    end
endmodule

module dadda_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [31:0]           res_product,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id_r;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic [31:0]     mul_product;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return ID_W'(s);
    endfunction

    // Search upward from ptr with wrap-around for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr, k);
            end else begin
                grant_found = grant_found;
            end
        end
    end

    // Accept strobe is combinational so the requester sees it in the grant cycle.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign sel_a = req_a[int'(grant_idx)*16 +: 16];
    assign sel_b = req_b[int'(grant_idx)*16 +: 16];

    dadda u_dadda (
        .a       (op_a),
        .b       (op_b),
        .product (mul_product)
    );

    // Scheduler FSM with registered result and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id_r        <= '0;
            op_a        <= 16'h0000;
            op_b        <= 16'h0000;
            res_valid   <= 1'b0;
            res_product <= 32'h0000_0000;
            res_id      <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        id_r  <= grant_idx;
                        ptr   <= wrap_idx(grant_idx, 1);
                        state <= MUL;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MUL: begin
                    res_product <= mul_product;
                    res_id      <= id_r;
                    res_valid   <= 1'b1;
                    state       <= HOLD;
                    busy        <= 1'b1;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        state <= HOLD;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dadda_share_arbiter.sv
// Directed and random self-checking bench for dadda_share_arbiter (4 requesters).

module tb_dadda_share_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [31:0] res_product;
    logic        busy;

    int total  = 0;
    int passed = 0;

    dadda_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at a negedge in IDLE with requester g expected to win the grant.
    task automatic expect_txn(input int g, input logic [31:0] prod);
        logic [3:0] onehot;
        onehot = 4'b0001 << g;
        #1;
        chk("grant", {28'h0, req_ready}, {28'h0, onehot});
        tick();
        req_valid[g] = 1'b0;
        #1;
        chk("mul_ready", {28'h0, req_ready}, 32'd0);
        chk("mul_busy", {31'h0, busy}, 32'd1);
        chk("mul_res_valid", {31'h0, res_valid}, 32'd0);
        tick();
        chk("res_valid", {31'h0, res_valid}, 32'd1);
        chk("res_product", res_product, prod);
        chk("res_id", {30'h0, res_id}, g);
        chk("hold_ready", {28'h0, req_ready}, 32'd0);
        tick();
        chk("res_drop", {31'h0, res_valid}, 32'd0);
    endtask

    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [3:0]  acc;
    logic [31:0] pa;
    logic [31:0] pb;
    int launched;
    int done_cnt;
    int cyc;

    initial begin
        rst       = 1'b1;
        req_valid = 4'h0;
        req_a     = 64'h0;
        req_b     = 64'h0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("rst_res_valid", {31'h0, res_valid}, 32'd0);
        chk("rst_res_product", res_product, 32'd0);
        chk("rst_res_id", {30'h0, res_id}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_req_ready", {28'h0, req_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // All four valid together: served 0,1,2,3 three cycles apart.
        set_op(0, 16'h0002, 16'h0003);
        set_op(1, 16'h0010, 16'h0010);
        set_op(2, 16'hFFFF, 16'hFFFF);
        set_op(3, 16'h1234, 16'h0000);
        req_valid = 4'hF;
        expect_txn(0, 32'd6);
        expect_txn(1, 32'd256);
        expect_txn(2, 32'hFFFE_0001);
        expect_txn(3, 32'd0);

        // Single request from requester 1.
        set_op(1, 16'd3, 16'd5);
        req_valid = 4'b0010;
        expect_txn(1, 32'd15);
        tick();
        chk("single_pulse", {31'h0, res_valid}, 32'd0);
        chk("single_idle_busy", {31'h0, busy}, 32'd0);

        // Fairness: after granting 2, requesters 0 and 3 together -> 3 then 0.
        set_op(2, 16'd2, 16'd2);
        req_valid = 4'b0100;
        expect_txn(2, 32'd4);
        set_op(0, 16'd7, 16'd9);
        set_op(3, 16'h0100, 16'h0100);
        req_valid = 4'b1001;
        expect_txn(3, 32'h0001_0000);
        expect_txn(0, 32'd63);

        // Backpressure: stall five cycles in HOLD while requester 0 waits.
        set_op(1, 16'd11, 16'd13);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        #1;
        chk("bp_grant", {28'h0, req_ready}, 32'h2);
        tick();
        req_valid = 4'b0001;
        set_op(0, 16'd5, 16'd6);
        #1;
        chk("bp_mul_ready", {28'h0, req_ready}, 32'd0);
        tick();
        chk("bp_res_valid", {31'h0, res_valid}, 32'd1);
        chk("bp_res_product", res_product, 32'd143);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", {31'h0, res_valid}, 32'd1);
            chk("bp_hold_product", res_product, 32'd143);
            chk("bp_hold_id", {30'h0, res_id}, 32'd1);
            chk("bp_hold_ready", {28'h0, req_ready}, 32'd0);
            chk("bp_hold_busy", {31'h0, busy}, 32'd1);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release", {31'h0, res_valid}, 32'd0);
        expect_txn(0, 32'd30);

        // Reset while in MUL: in-flight product discarded, ptr back to 0.
        set_op(2, 16'd9, 16'd9);
        req_valid = 4'b0100;
        #1;
        chk("rm_grant", {28'h0, req_ready}, 32'h4);
        tick();
        set_op(1, 16'h8000, 16'd2);
        set_op(3, 16'd1, 16'd1);
        req_valid = 4'b1110;
        rst = 1'b1;
        #1;
        chk("rm_res_valid", {31'h0, res_valid}, 32'd0);
        chk("rm_res_product", res_product, 32'd0);
        chk("rm_res_id", {30'h0, res_id}, 32'd0);
        chk("rm_busy", {31'h0, busy}, 32'd0);
        chk("rm_req_ready", {28'h0, req_ready}, 32'd0);
        tick();
        chk("rm_no_pulse", {31'h0, res_valid}, 32'd0);
        rst = 1'b0;
        expect_txn(1, 32'h0001_0000);
        expect_txn(2, 32'd81);
        expect_txn(3, 32'd1);
        req_valid = 4'h0;
        tick();

        // Random regression with a scoreboard of accepted requests.
        launched = 0;
        done_cnt = 0;
        cyc      = 0;
        while ((launched < 1000 || req_valid != 4'h0 || exp_q.size() != 0) && cyc < 30000) begin
            #1;
            if (res_valid && res_ready) begin
                chk("rnd_qsize", exp_q.size(), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rnd_product", res_product, e[31:0]);
                    chk("rnd_id", {30'h0, res_id}, {30'h0, e[33:32]});
                    done_cnt++;
                end
            end
            acc = req_ready;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    pa = {16'h0000, req_a[16*i +: 16]};
                    pb = {16'h0000, req_b[16*i +: 16]};
                    exp_q.push_back({2'(i), pa * pb});
                end
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && launched < 1000 && $urandom_range(0, 2) == 0) begin
                    set_op(i, rnd16(), rnd16());
                    req_valid[i] = 1'b1;
                    launched++;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("rnd_done", done_cnt, 32'd1000);
        chk("rnd_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dadda_share_arbiter.md
# dadda_share_arbiter

Round-robin scheduler that time-shares one 16x16 combinational `dadda` multiplier among `NUM_REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted operands, drives the shared `dadda` instance, and returns the registered 32-bit product tagged with the requester index through a single valid/ready result port. It sits between client datapaths and the multiplier, and instantiates `dadda` internally.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `ID_W`, 2: tag width. Must equal clog2(`NUM_REQ`); the integrator sets it.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input `NUM_REQ`: per-requester operand valid.
- `req_ready` output `NUM_REQ`: per-requester accept. One-hot or zero.
- `req_a` input 16*`NUM_REQ`: flattened multiplicands. Requester i uses bits [16i+15:16i].
- `req_b` input 16*`NUM_REQ`: flattened multipliers, packed the same way as `req_a`.
- `res_valid` output 1: product valid.
- `res_ready` input 1: downstream accepts product.
- `res_id` output `ID_W`: index of the requester that owns the product.
- `res_product` output 32: unsigned a*b.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, MUL, HOLD.
- IDLE:
  - Grant goes to the first asserted `req_valid` found by searching upward from pointer `ptr`, with wrap-around.
  - `req_ready[g]` = 1 combinationally for the granted index g only.
  - On that edge, register `req_a[g]` into `op_a`, `req_b[g]` into `op_b`, and g into `id_r`.
  - Set `ptr` ← (g+1) mod `NUM_REQ`, then go to MUL.
  - If no `req_valid` is asserted: stay in IDLE, all `req_ready` = 0.
- MUL:
  - `dadda(op_a, op_b)` is evaluated combinationally.
  - At the edge: `res_product` ← product, `res_id` ← `id_r`, `res_valid` ← 1. Go to HOLD.
- HOLD:
  - `res_valid` = 1. `res_product` and `res_id` stay stable.
  - When `res_ready` = 1: clear `res_valid` at the edge and go to IDLE.
  - No new request is granted in HOLD; all `req_ready` = 0.
- `req_ready` is 0 in MUL and HOLD.
- Requesters must hold `req_valid` and their operands stable until they see `req_ready`. The arbiter does not latch requests that are not granted.
- Arithmetic is unsigned and full-width. The maximum result is 0xFFFF*0xFFFF = 0xFFFE0001; there is no truncation or overflow.
- `ptr` changes only on an accepted request. Requesters that were skipped keep their priority order.
- A requester that drops `req_valid` before grant is simply not served. This is not an error.

## Timing
- Reset (asynchronous, effective immediately):
  - state = IDLE, `ptr` = 0, `op_a` = `op_b` = 0, `id_r` = 0.
  - `res_valid` = 0, `res_product` = 0, `res_id` = 0, `busy` = 0, `req_ready` = 0.
- Reset mid-operation (in MUL or HOLD): any in-flight product is discarded and no `res_valid` pulse follows. After reset deasserts, the first grant goes to the lowest-indexed valid requester.
- Latency:
  - Request accepted at edge k → `res_valid` high after edge k+1. The product is visible in the cycle following k+1.
  - Minimum issue interval is 3 cycles: accept, MUL, HOLD with `res_ready` = 1.
- With `res_ready` held at 1: `res_valid` is high for exactly one cycle per product.
- With `res_ready` = 0: the block stalls in HOLD indefinitely and the outputs are frozen.
- Simultaneous requests: exactly one is granted per IDLE cycle. No combinational path exists from `res_ready` to `req_ready`.
- `busy` is registered from state. It is 1 during MUL and HOLD, and 0 in IDLE.

## Test plan
- Single request: requester 1 sends a=3, b=5 with `res_ready` = 1. Required: `req_ready[1]` pulses once, then two edges later `res_valid` = 1, `res_product` = 15, `res_id` = 1 for one cycle.
- All four requesters valid and held until accepted (operands 0x0002*0x0003, 0x0010*0x0010, 0xFFFF*0xFFFF, 0x1234*0x0000). Required grant order is 0,1,2,3, with products 6, 256, 0xFFFE0001, 0, each issued 3 cycles apart.
- Fairness: after a grant to requester 2, requesters 0 and 3 assert together. Required: 3 is granted first, then 0.
- Backpressure: `res_ready` = 0 for 5 cycles during HOLD while requester 0 is valid. Required: `res_valid`, `res_product` and `res_id` stay stable, `req_ready` = 0 throughout, and requester 0 is granted the cycle after `res_ready` rises.
- Reset in MUL: assert `rst` one cycle after an accept. Required: all outputs go to zero immediately, no `res_valid` pulse follows, and `ptr` = 0.
- Random regression: 1000 random operand pairs with random `req_valid`/`res_ready` patterns. Each product must match a*b and its `res_id`, and no request may be lost or duplicated.
